// File: rtl/codec_i2c_master.sv
// Bit-level I2C master for codec register access.
// Open-drain SCL/SDA, single master, no clock stretching.
module codec_i2c_master #(
  parameter int          CLK_DIV  = 250,
  parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       codec_rd_en,
  input  logic       codec_wr_en,
  input  logic [8:0] codec_reg_addr,
  input  logic [7:0] codec_data_out,
  output logic [7:0] codec_data_in,
  output logic       codec_data_in_valid,
  output logic       busy,
  output logic       ack_error,
  output logic       scl_drive_low,
  output logic       sda_drive_low,
  input  logic       sda_in
);

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    TX_DEV_W,
    TX_REG,
    TX_DATA,
    RESTART,
    TX_DEV_R,
    RX_DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic [9:0] qcnt;
  logic [1:0] q;
  logic [3:0] bcnt;
  logic [7:0] addr_r;
  logic [7:0] wdata_r;
  logic [7:0] rx_sr;
  logic       is_read;
  logic       nack;

  logic       qend;
  logic       bit_end;
  logic       sample;
  logic       last_bit;
  logic       tx_state;
  logic       accept;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       unused_addr_msb;

  assign unused_addr_msb = codec_reg_addr[8];

  assign qend     = (qcnt == QMAX);
  assign bit_end  = qend && (q == 2'd3);
  assign sample   = qend && (q == 2'd2);
  assign last_bit = (bcnt == 4'd8);
  assign accept   = (state == IDLE) &&
                    (codec_wr_en || codec_rd_en);
  assign tx_state = (state == TX_DEV_W) ||
                    (state == TX_REG) ||
                    (state == TX_DATA) ||
                    (state == TX_DEV_R);
  assign busy     = (state != IDLE);

  always_comb begin
    tx_byte = 8'h00;
    unique case (state)
      TX_DEV_W: tx_byte = {DEV_ADDR, 1'b0};
      TX_REG:   tx_byte = addr_r;
      TX_DATA:  tx_byte = wdata_r;
      TX_DEV_R: tx_byte = {DEV_ADDR, 1'b1};
      default:  tx_byte = 8'h00;
    endcase
  end

  assign tx_bit = tx_byte[3'd7 - bcnt[2:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A NACK on any transmitted byte skips straight to STOP.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (accept) state_n = START;
      START:
        if (bit_end) state_n = TX_DEV_W;
      TX_DEV_W:
        if (bit_end && last_bit)
          state_n = nack ? STOP : TX_REG;
      TX_REG:
        if (bit_end && last_bit) begin
          if (nack)         state_n = STOP;
          else if (is_read) state_n = RESTART;
          else              state_n = TX_DATA;
        end
      TX_DATA:
        if (bit_end && last_bit) state_n = STOP;
      RESTART:
        if (bit_end) state_n = TX_DEV_R;
      TX_DEV_R:
        if (bit_end && last_bit)
          state_n = nack ? STOP : RX_DATA;
      RX_DATA:
        if (bit_end && last_bit) state_n = STOP;
      STOP:
        if (bit_end) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    scl_drive_low = 1'b0;
    sda_drive_low = 1'b0;
    unique case (state)
      START: begin
        scl_drive_low = (q == 2'd3);
        sda_drive_low = q[1];
      end
      RESTART: begin
        scl_drive_low = (q == 2'd0) || (q == 2'd3);
        sda_drive_low = q[1];
      end
      STOP: begin
        scl_drive_low = (q == 2'd0);
        sda_drive_low = ~q[1];
      end
      TX_DEV_W, TX_REG, TX_DATA, TX_DEV_R: begin
        scl_drive_low = ~q[1];
        sda_drive_low = !last_bit && !tx_bit;
      end
      RX_DATA: begin
        scl_drive_low = ~q[1];
        sda_drive_low = 1'b0;
      end
      default: begin
        scl_drive_low = 1'b0;
        sda_drive_low = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt                <= '0;
      q                   <= '0;
      bcnt                <= '0;
      addr_r              <= '0;
      wdata_r             <= '0;
      rx_sr               <= '0;
      is_read             <= 1'b0;
      nack                <= 1'b0;
      codec_data_in       <= '0;
      codec_data_in_valid <= 1'b0;
      ack_error           <= 1'b0;
    end else begin
      codec_data_in_valid <= 1'b0;
      ack_error           <= 1'b0;
      if (state == IDLE) begin
        qcnt <= '0;
        q    <= '0;
        bcnt <= '0;
        if (accept) begin
          addr_r  <= codec_reg_addr[7:0];
          wdata_r <= codec_data_out;
          is_read <= codec_rd_en && !codec_wr_en;
          nack    <= 1'b0;
        end
      end else begin
        qcnt <= qend ? 10'd0 : qcnt + 10'd1;
        if (qend) q <= q + 2'd1;
        if (bit_end)
          bcnt <= (state_n != state) ? 4'd0 : bcnt + 4'd1;
        if (sample && tx_state && last_bit && sda_in)
          nack <= 1'b1;
        if (sample && (state == RX_DATA) && !last_bit)
          rx_sr <= {rx_sr[6:0], sda_in};
        // A failed read still returns zero data so requesters never hang.
        if ((state == STOP) && bit_end) begin
          ack_error <= nack;
          if (is_read) begin
            codec_data_in       <= nack ? 8'h00 : rx_sr;
            codec_data_in_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
